// File: rtl/ram_sp_readback_checker.sv
// Snoops a single-port RAM, shadows every write, and checks read data
// against the shadow after RD_LAT cycles, with sticky first-error capture.
module ram_sp_readback_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wren,
  input  logic              rden,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] q,
  output logic [1:0]        status,
  output logic [15:0]       chk_cnt,
  output logic [15:0]       err_cnt,
  output logic [15:0]       unw_cnt,
  output logic [15:0]       col_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_act
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PASS = 2'b01,
    FAIL = 2'b10
  } state_t;

  typedef struct packed {
    logic              v;
    logic              wv;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } chk_t;

  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DEPTH-1:0]  vld;
  chk_t              pipe [RD_LAT];
  chk_t              tail;
  state_t            state, state_n;

  logic wr_go, rd_go, col_go;
  logic done, cmp, miss, unw, first_miss;

  assign wr_go  = !clr && wren;
  assign rd_go  = !clr && rden && !wren;
  assign col_go = !clr && rden && wren;

  assign tail       = pipe[RD_LAT-1];
  assign done       = !clr && tail.v;
  assign cmp        = done && tail.wv;
  assign miss       = cmp && (q != tail.exp);
  assign unw        = done && !tail.wv;
  assign first_miss = miss && (state != FAIL);

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Shadow data is don't-care until its valid bit is set
  always_ff @(posedge clk) begin
    if (wr_go) shadow[address] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (clr) begin
      vld <= '0;
    end else if (wr_go) begin
      vld[address] <= 1'b1;
    end
  end

  // Expected value is frozen at launch, so later writes cannot disturb it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0].v    <= rd_go;
      pipe[0].wv   <= vld[address];
      pipe[0].addr <= address;
      pipe[0].exp  <= shadow[address];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_cnt <= '0;
      err_cnt <= '0;
      unw_cnt <= '0;
      col_cnt <= '0;
    end else if (clr) begin
      chk_cnt <= '0;
      err_cnt <= '0;
      unw_cnt <= '0;
      col_cnt <= '0;
    end else begin
      if (cmp)    chk_cnt <= sat_inc(chk_cnt);
      if (miss)   err_cnt <= sat_inc(err_cnt);
      if (unw)    unw_cnt <= sat_inc(unw_cnt);
      if (col_go) col_cnt <= sat_inc(col_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_act  <= '0;
    end else if (clr) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_act  <= '0;
    end else if (first_miss) begin
      err_addr <= tail.addr;
      err_exp  <= tail.exp;
      err_act  <= q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (clr) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss)     state_n = FAIL;
          else if (cmp) state_n = PASS;
        end
        PASS: if (miss) state_n = FAIL;
        FAIL: state_n = FAIL;
        default: state_n = IDLE;
      endcase
    end
  end

  assign status = state;

endmodule

// File: tb/tb_ram_sp_readback_checker.sv
// Scoreboard bench: directed RAM traffic with a behavioural RAM model;
// expected snapshots are queued by stimulus and checked by a monitor.
module tb_ram_sp_readback_checker;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic          clk, rst, clr, wren, rden;
  logic [AW-1:0] address;
  logic [DW-1:0] data, q;
  logic [1:0]    status;
  logic [15:0]   chk_cnt, err_cnt, unw_cnt, col_cnt;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp, err_act;

  ram_sp_readback_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wren(wren), .rden(rden), .address(address),
    .data(data), .q(q), .status(status),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .unw_cnt(unw_cnt), .col_cnt(col_cnt),
    .err_addr(err_addr), .err_exp(err_exp), .err_act(err_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with optional corrupted read at one address
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] qp  [LAT];
  logic          bad_en;
  logic [AW-1:0] bad_addr;

  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    if (rden)
      qp[0] <= (bad_en && address == bad_addr) ? 8'hFF : mem[address];
    for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
  end
  assign q = qp[LAT-1];

  typedef struct {
    logic [1:0]  st;
    logic [15:0] chk, err, unw, col;
    logic [7:0]  ea, ee, eact;
  } snap_t;

  snap_t sb[$];
  int    n_chk;
  int    n_fail;

  task automatic cmp_f(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp_f("status",   {14'd0, status}, {14'd0, e.st});
        cmp_f("chk_cnt",  chk_cnt, e.chk);
        cmp_f("err_cnt",  err_cnt, e.err);
        cmp_f("unw_cnt",  unw_cnt, e.unw);
        cmp_f("col_cnt",  col_cnt, e.col);
        cmp_f("err_addr", {8'd0, err_addr}, {8'd0, e.ea});
        cmp_f("err_exp",  {8'd0, err_exp},  {8'd0, e.ee});
        cmp_f("err_act",  {8'd0, err_act},  {8'd0, e.eact});
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic c,
                       input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    wren = w; rden = r; clr = c; address = a; data = d;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, 1'b0, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    drive(1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic push(input logic [1:0] st, input logic [15:0] chk,
                      input logic [15:0] err, input logic [15:0] unw,
                      input logic [15:0] col, input logic [7:0] ea,
                      input logic [7:0] ee, input logic [7:0] eact);
    snap_t e;
    e.st = st; e.chk = chk; e.err = err; e.unw = unw; e.col = col;
    e.ea = ea; e.ee = ee; e.eact = eact;
    sb.push_back(e);
  endtask

  task automatic expect_after_drain(input logic [1:0] st,
      input logic [15:0] chk, input logic [15:0] err,
      input logic [15:0] unw, input logic [15:0] col,
      input logic [7:0] ea, input logic [7:0] ee, input logic [7:0] eact);
    idle(LAT + 2);
    push(st, chk, err, unw, col, ea, ee, eact);
    idle(1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; clr = 1'b0; wren = 1'b0; rden = 1'b0;
    address = '0; data = '0; bad_en = 1'b0; bad_addr = '0;
    for (int i = 0; i < LAT; i++) qp[i] = '0;

    push(2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Clean write/readback of 10..20
    for (int a = 10; a <= 20; a++) wr(8'(a), 8'(a));
    for (int a = 10; a <= 20; a++) rd(8'(a));
    expect_after_drain(2'b01, 11, 0, 0, 0, 0, 0, 0);

    // Corrupted read at 15 enters FAIL; a later match stays FAIL
    bad_en = 1'b1; bad_addr = 8'd15;
    for (int a = 10; a <= 20; a++) rd(8'(a));
    expect_after_drain(2'b10, 22, 1, 0, 0, 8'd15, 8'd15, 8'hFF);
    bad_en = 1'b0;
    rd(8'd12);
    expect_after_drain(2'b10, 23, 1, 0, 0, 8'd15, 8'd15, 8'hFF);

    drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    expect_after_drain(2'b00, 0, 0, 0, 0, 0, 0, 0);

    // Never-written address
    rd(8'd200);
    expect_after_drain(2'b00, 0, 0, 1, 0, 0, 0, 0);

    // Collision acts as a write only
    drive(1'b1, 1'b1, 1'b0, 8'd5, 8'h33);
    rd(8'd5);
    expect_after_drain(2'b01, 1, 0, 1, 1, 0, 0, 0);

    // Write behind an in-flight read must not change its expectation
    wr(8'd7, 8'h07);
    rd(8'd7);
    wr(8'd7, 8'h99);
    expect_after_drain(2'b01, 2, 0, 1, 1, 0, 0, 0);
    rd(8'd7);
    expect_after_drain(2'b01, 3, 0, 1, 1, 0, 0, 0);

    // Enter FAIL, then clear with a check in flight
    wr(8'd30, 8'h30);
    bad_en = 1'b1; bad_addr = 8'd30;
    rd(8'd30);
    expect_after_drain(2'b10, 4, 1, 1, 1, 8'd30, 8'h30, 8'hFF);
    rd(8'd30);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    expect_after_drain(2'b00, 0, 0, 0, 0, 0, 0, 0);
    bad_en = 1'b0;
    rd(8'd30);
    expect_after_drain(2'b00, 0, 0, 1, 0, 0, 0, 0);

    // Reset in the middle of a check
    wr(8'd5, 8'h55);
    rd(8'd5);
    @(negedge clk);
    rst = 1'b1; wren = 1'b0; rden = 1'b0;
    push(2'b00, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    rst = 1'b0;
    expect_after_drain(2'b00, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d snapshots left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
